// File: rtl/decode_pkg.sv
// Shared definitions for the MIPS-subset decode stage: opcode/funct codes,
// ALU operation encoding, the control word and small decode helpers.
package decode_pkg;

  localparam int ALUOP_WIDTH = 4;
  localparam logic [4:0] REG_LINK = 5'd31;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [ALUOP_WIDTH-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } aluop_e;

  typedef struct packed {
    aluop_e aluop;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   immsel;
    logic   branch;
    logic   bne;
    logic   jump;
    logic   link;
    logic   illegal;
  } ctrl_t;

  // Instructions that read rt as a source operand (matters for load-use hazards)
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/decode_if.sv
// Handshake and bus bundle between fetch, decode and execute.
// The master side is the decode stage itself; the slave side is its environment.
interface decode_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic [DATA_W-1:0]  in_pc;
  logic               flush;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_pc;
  logic [REG_AW-1:0]  out_rs;
  logic [REG_AW-1:0]  out_rt;
  logic [REG_AW-1:0]  out_rd;
  logic [REG_AW-1:0]  out_dst;
  logic [4:0]         out_shamt;
  logic [DATA_W-1:0]  out_imm_ext;
  logic [25:0]        out_adr;
  logic [ALUOP_W-1:0] out_aluop;
  logic               out_regwrite;
  logic               out_memread;
  logic               out_memwrite;
  logic               out_immsel;
  logic               out_branch;
  logic               out_bne;
  logic               out_jump;
  logic               out_link;
  logic               out_illegal;

  modport master (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_dst,
           out_shamt, out_imm_ext, out_adr, out_aluop, out_regwrite,
           out_memread, out_memwrite, out_immsel, out_branch, out_bne,
           out_jump, out_link, out_illegal
  );

  modport slave (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_dst,
           out_shamt, out_imm_ext, out_adr, out_aluop, out_regwrite,
           out_memread, out_memwrite, out_immsel, out_branch, out_bne,
           out_jump, out_link, out_illegal
  );

endinterface

// File: rtl/decode_ctrl.sv
// Purely combinational decoder: opcode/funct to control word, immediate
// extension and write-back register selection.
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  output ctrl_t             ctrl,
  output logic [DATA_W-1:0] imm_ext,
  output logic [4:0]        dst
);

  // Control word; unknown opcodes and functs leave only the illegal flag set
  always_comb begin
    ctrl       = '0;
    ctrl.aluop = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_ADD; end
          FN_SUB:          begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_SUB; end
          FN_AND:          begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_AND; end
          FN_OR:           begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_OR;  end
          FN_SLT:          begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_SLT; end
          default:         ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin ctrl.regwrite = 1'b1; ctrl.immsel = 1'b1; ctrl.aluop = ALU_ADD; end
      OP_ANDI: begin ctrl.regwrite = 1'b1; ctrl.immsel = 1'b1; ctrl.aluop = ALU_AND; end
      OP_ORI:  begin ctrl.regwrite = 1'b1; ctrl.immsel = 1'b1; ctrl.aluop = ALU_OR;  end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.immsel   = 1'b1;
      end
      OP_SW: begin ctrl.memwrite = 1'b1; ctrl.immsel = 1'b1; end
      OP_BEQ: begin ctrl.branch = 1'b1; ctrl.aluop = ALU_SUB; end
      OP_BNE: begin ctrl.branch = 1'b1; ctrl.bne = 1'b1; ctrl.aluop = ALU_SUB; end
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: begin ctrl.jump = 1'b1; ctrl.regwrite = 1'b1; ctrl.link = 1'b1; end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  // Logical immediates zero-extend, everything else sign-extends bit 15
  always_comb begin
    if ((opcode == OP_ANDI) || (opcode == OP_ORI))
      imm_ext = {{(DATA_W-16){1'b0}}, imm};
    else
      imm_ext = {{(DATA_W-16){imm[15]}}, imm};
  end

  // Write-back target: rd for R-type, the link register for jal, rt otherwise
  always_comb begin
    if (opcode == OP_RTYPE)
      dst = rd;
    else if (opcode == OP_JAL)
      dst = REG_LINK;
    else
      dst = rt;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage with ID/EX pipeline register, load-use bubble insertion,
// redirect flush and a saturating count of inserted bubbles.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 4,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  decode_if.master            bus,
  output logic [STALL_CW-1:0] stall_cnt
);

  localparam logic [STALL_CW-1:0] STALL_MAX = '1;

  logic [5:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_adr;

  ctrl_t             dec_ctrl;
  logic [DATA_W-1:0] dec_imm;
  logic [4:0]        dec_dst;

  logic              valid_q;
  logic [DATA_W-1:0] pc_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] dst_q;
  logic [4:0]        shamt_q;
  logic [DATA_W-1:0] imm_q;
  logic [25:0]       adr_q;
  ctrl_t             ctrl_q;

  logic              hazard;
  logic              in_ready_int;
  logic              accept;

  assign in_op    = bus.in_instr[31:26];
  assign in_rs    = bus.in_instr[25:21];
  assign in_rt    = bus.in_instr[20:16];
  assign in_rd    = bus.in_instr[15:11];
  assign in_shamt = bus.in_instr[10:6];
  assign in_funct = bus.in_instr[5:0];
  assign in_imm   = bus.in_instr[15:0];
  assign in_adr   = bus.in_instr[25:0];

  decode_ctrl #(.DATA_W(DATA_W)) u_ctrl (
    .opcode  (in_op),
    .funct   (in_funct),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .ctrl    (dec_ctrl),
    .imm_ext (dec_imm),
    .dst     (dec_dst)
  );

  // A load sitting in ID/EX whose rt feeds the incoming instruction must bubble
  assign hazard = valid_q & ctrl_q.memread & (rt_q != '0) &
                  ((rt_q == REG_AW'(in_rs)) |
                   (uses_rt(in_op) & (rt_q == REG_AW'(in_rt))));

  assign in_ready_int = (~valid_q | bus.out_ready) & ~hazard & ~bus.flush & ~rst;
  assign accept       = bus.in_valid & in_ready_int;
  assign bus.in_ready = in_ready_int;

  // ID/EX register: flush kills, accept loads, consumption drains, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      dst_q     <= '0;
      shamt_q   <= '0;
      imm_q     <= '0;
      adr_q     <= '0;
      ctrl_q    <= '0;
      stall_cnt <= '0;
    end else begin
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        pc_q    <= bus.in_pc;
        rs_q    <= REG_AW'(in_rs);
        rt_q    <= REG_AW'(in_rt);
        rd_q    <= REG_AW'(in_rd);
        dst_q   <= REG_AW'(dec_dst);
        shamt_q <= in_shamt;
        imm_q   <= dec_imm;
        adr_q   <= in_adr;
        ctrl_q  <= dec_ctrl;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (hazard & bus.out_ready & ~bus.flush & (stall_cnt != STALL_MAX))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_rs       = rs_q;
  assign bus.out_rt       = rt_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_dst      = dst_q;
  assign bus.out_shamt    = shamt_q;
  assign bus.out_imm_ext  = imm_q;
  assign bus.out_adr      = adr_q;
  assign bus.out_aluop    = ALUOP_W'(ctrl_q.aluop);
  assign bus.out_regwrite = ctrl_q.regwrite;
  assign bus.out_memread  = ctrl_q.memread;
  assign bus.out_memwrite = ctrl_q.memwrite;
  assign bus.out_immsel   = ctrl_q.immsel;
  assign bus.out_branch   = ctrl_q.branch;
  assign bus.out_bne      = ctrl_q.bne;
  assign bus.out_jump     = ctrl_q.jump;
  assign bus.out_link     = ctrl_q.link;
  assign bus.out_illegal  = ctrl_q.illegal;

endmodule
